n2_dmem_bridge: RTL
===================

N2_DMEM_BRIDGE -- requirements
Module: N2_dmem_bridge

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of granted requests awaiting a memory response (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 32, the width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 data_req_i  in  1  LSU request valid.
REQ-006 data_we_i  in  1  LSU request is a store.
REQ-007 data_addr_i  in  32  LSU byte address.
REQ-008 data_wdata_i  in  32  LSU store data, already lane-replicated.
REQ-009 data_wstrb_i  in  4  LSU byte strobes; zero for loads.
REQ-010 data_gnt_o  out  1  request accepted this cycle.
REQ-011 data_ready_o  out  1  load data valid on data_rdata_o; asserted for loads only.
REQ-012 data_rdata_o  out  32  load data returned to the LSU.
REQ-013 mem_req_valid_o, mem_req_ready_i  out/in  1 each  memory request handshake.
REQ-014 mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o  out  1/32/32/4  memory request payload.
REQ-015 mem_resp_valid_i, mem_resp_rdata_i  in  1/32  memory response, one per accepted request, in order, for loads and stores alike.
REQ-016 ld_cnt_o, st_cnt_o  out  CNT_W each  count of granted loads and granted stores.
REQ-017 err_o  out  1  sticky protocol error flag.

Function
REQ-018 SHALL pass the request combinationally: mem_req_valid_o = data_req_i & ~full; payload outputs equal the corresponding data_*_i inputs.
REQ-019 SHALL assert data_gnt_o = data_req_i & ~full & mem_req_ready_i; no request registering is allowed, so the LSU fetch pointer advances in the same cycle.
REQ-020 SHALL keep an in-order outstanding FIFO of MAX_OUTSTANDING one-bit entries (is_store), pushed on data_gnt_o with data_we_i.
REQ-021 full SHALL be asserted when the count equals MAX_OUTSTANDING.
REQ-022 On mem_resp_valid_i with the FIFO non-empty, SHALL pop the head entry.
REQ-023 If the popped entry is a load, SHALL drive data_ready_o=1 and data_rdata_o=mem_resp_rdata_i in the next cycle (one-cycle registered latency).
REQ-024 If the popped entry is a store, SHALL drop the response, with data_ready_o=0.
REQ-025 data_ready_o SHALL be a single-cycle pulse per load response; data_rdata_o SHALL hold its last value otherwise.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged. A pop on a full FIFO frees the slot only from the next cycle, so grant is still blocked in the pop cycle.
REQ-027 Read and write pointers SHALL wrap modulo MAX_OUTSTANDING; the count SHALL range 0..MAX_OUTSTANDING.
REQ-028 mem_resp_valid_i with the FIFO empty SHALL be ignored (no pop, no data_ready_o) and SHALL set err_o.
REQ-029 A granted load with data_addr_i not naturally aligned for its strobe pattern (word at addr[1:0]!=0) is still forwarded and SHALL NOT set err_o; alignment is the LSU's responsibility.
REQ-030 ld_cnt_o SHALL increment on each granted load and st_cnt_o on each granted store, wrapping at 2^CNT_W.

Reset
REQ-031 While rst=1 SHALL clear FIFO pointers, count, data_ready_o, data_rdata_o (0), ld_cnt_o, st_cnt_o and err_o; err_o is cleared only by rst.
REQ-032 During rst=1 SHALL hold data_gnt_o=0 and mem_req_valid_o=0 regardless of data_req_i.
REQ-033 Responses arriving during rst SHALL be discarded; outstanding requests are forgotten on reset mid-operation.

Verification
REQ-034 Single load: addr 0x100, mem_req_ready_i=1, response rdata 0xDEADBEEF two cycles later -> gnt in the request cycle; data_ready_o pulse one cycle after the response with rdata 0xDEADBEEF; ld_cnt_o=1.
REQ-035 Store then load back-to-back, responses for both -> exactly one data_ready_o pulse, carrying the load data; st_cnt_o=1, ld_cnt_o=1.
REQ-036 Five loads with mem_req_ready_i=1 and no responses -> first 4 granted, 5th held with gnt=0 and mem_req_valid_o=0; one response -> 5th granted the cycle after the pop.
REQ-037 mem_req_ready_i=0 for 3 cycles with a request pending -> gnt=0 and count unchanged for those cycles, then gnt=1 on the first cycle with ready=1.
REQ-038 Response with the FIFO empty -> err_o=1 and stays 1, no data_ready_o; then rst for one cycle -> err_o=0, counters=0.
REQ-039 10 alternating load/store requests with responses randomly delayed 0-5 cycles -> data_ready_o count=5, rdata in request order, pointers wrap correctly.

Source files
------------

// File: rtl/n2_dmem_bridge_if.sv
// -----------------------------------------------------------------------------
// n2_dmem_bridge_if
//
// Groups the LSU-side and memory-side signals of the data-memory bridge into
// one bundle. Signal names keep the bridge's _i/_o naming, seen from the
// bridge itself.
//
//   LSU request   : data_req_i, data_we_i, data_addr_i[31:0],
//                   data_wdata_i[31:0], data_wstrb_i[3:0]
//   LSU response  : data_gnt_o, data_ready_o, data_rdata_o[31:0]
//   Mem request   : mem_req_valid_o, mem_req_ready_i, mem_req_we_o,
//                   mem_req_addr_o[31:0], mem_req_wdata_o[31:0],
//                   mem_req_wstrb_o[3:0]
//   Mem response  : mem_resp_valid_i, mem_resp_rdata_i[31:0]
//
// Modports:
//   slave  - the bridge (consumes LSU requests and memory responses)
//   master - the surroundings (LSU plus memory model)
// -----------------------------------------------------------------------------
interface n2_dmem_bridge_if;

    // LSU side
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_wstrb_i;
    logic        data_gnt_o;
    logic        data_ready_o;
    logic [31:0] data_rdata_o;

    // Memory side
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_req_we_o;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_wstrb_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_rdata_i;

    modport slave (
        input  data_req_i,
        input  data_we_i,
        input  data_addr_i,
        input  data_wdata_i,
        input  data_wstrb_i,
        output data_gnt_o,
        output data_ready_o,
        output data_rdata_o,
        output mem_req_valid_o,
        input  mem_req_ready_i,
        output mem_req_we_o,
        output mem_req_addr_o,
        output mem_req_wdata_o,
        output mem_req_wstrb_o,
        input  mem_resp_valid_i,
        input  mem_resp_rdata_i
    );

    modport master (
        output data_req_i,
        output data_we_i,
        output data_addr_i,
        output data_wdata_i,
        output data_wstrb_i,
        input  data_gnt_o,
        input  data_ready_o,
        input  data_rdata_o,
        input  mem_req_valid_o,
        output mem_req_ready_i,
        input  mem_req_we_o,
        input  mem_req_addr_o,
        input  mem_req_wdata_o,
        input  mem_req_wstrb_o,
        output mem_resp_valid_i,
        output mem_resp_rdata_i
    );

endinterface

// File: rtl/n2_dmem_bridge.sv
// -----------------------------------------------------------------------------
// n2_dmem_bridge
//
// Connects the core's load/store unit to a valid/ready data memory.
// Requests pass straight through combinationally, so the LSU sees its grant in
// the same cycle it asks. A small in-order FIFO remembers, for every granted
// request still waiting on memory, whether it was a store. Memory returns one
// response per accepted request in order; load responses are registered and
// handed to the LSU one cycle later, store responses are swallowed.
//
// Parameters:
//   MAX_OUTSTANDING - granted requests allowed in flight (power of two, 2..16)
//   CNT_W           - width of the load/store performance counters
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous, active-high reset
//   bus      - LSU and memory signals (n2_dmem_bridge_if.slave)
//   ld_cnt_o - number of granted loads (wraps)
//   st_cnt_o - number of granted stores (wraps)
//   err_o    - sticky: a memory response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module n2_dmem_bridge #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    n2_dmem_bridge_if.slave      bus,
    output logic [CNT_W-1:0]     ld_cnt_o,
    output logic [CNT_W-1:0]     st_cnt_o,
    output logic                 err_o
);

    // Pointers are log2(depth) wide so they wrap naturally at the depth;
    // the occupancy count needs one more bit to represent "full".
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(MAX_OUTSTANDING);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg,     wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg,     rd_ptr_next;
    logic [PTR_W:0]   count_reg,      count_next;
    logic             data_ready_reg, data_ready_next;
    logic [31:0]      data_rdata_reg, data_rdata_next;
    logic [CNT_W-1:0] ld_cnt_reg,     ld_cnt_next;
    logic [CNT_W-1:0] st_cnt_reg,     st_cnt_next;
    logic             err_reg,        err_next;

    // One is_store flag per FIFO slot, gathered from the generate block below.
    logic [MAX_OUTSTANDING-1:0] is_store_vec;

    // -------------------------------------------------------------------------
    // Request path (combinational)
    // -------------------------------------------------------------------------
    logic full;
    logic empty;
    logic req_ok;
    logic gnt;
    logic push;
    logic pop;
    logic head_is_store;
    logic load_resp;
    logic orphan_resp;

    // "full" looks at the registered count only: a response popping a full
    // FIFO does not open a slot until the following cycle, which keeps the
    // grant free of any combinational path from the memory response.
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

    // Reset gates the request off the bus so nothing leaks to memory while
    // the bookkeeping is being cleared.
    assign req_ok = bus.data_req_i & ~full & ~rst;
    assign gnt    = req_ok & bus.mem_req_ready_i;

    assign bus.mem_req_valid_o = req_ok;
    assign bus.mem_req_we_o    = bus.data_we_i;
    assign bus.mem_req_addr_o  = bus.data_addr_i;
    assign bus.mem_req_wdata_o = bus.data_wdata_i;
    assign bus.mem_req_wstrb_o = bus.data_wstrb_i;
    assign bus.data_gnt_o      = gnt;

    // Address alignment is deliberately not inspected: misaligned accesses
    // are the LSU's problem and are forwarded untouched.

    // -------------------------------------------------------------------------
    // Response path
    // -------------------------------------------------------------------------
    assign push          = gnt;
    assign pop           = bus.mem_resp_valid_i & ~empty & ~rst;
    assign head_is_store = is_store_vec[rd_ptr_reg];
    assign load_resp     = pop & ~head_is_store;
    // A response with nothing outstanding has no request to belong to.
    assign orphan_resp   = bus.mem_resp_valid_i & empty & ~rst;

    // -------------------------------------------------------------------------
    // Outstanding FIFO storage: one flag register per slot, written when the
    // write pointer selects it.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_entry
            logic entry_is_store_reg;
            logic entry_wr_en;

            assign entry_wr_en = push & (wr_ptr_reg == PTR_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_is_store_reg <= 1'b0;
                end else if (entry_wr_en) begin
                    entry_is_store_reg <= bus.data_we_i;
                end
            end

            assign is_store_vec[gi] = entry_is_store_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        data_ready_next = 1'b0;
        data_rdata_next = data_rdata_reg;
        ld_cnt_next     = ld_cnt_reg;
        st_cnt_next     = st_cnt_reg;
        err_next        = err_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase

        // Loads get a one-cycle pulse with the data captured alongside it;
        // the data register otherwise keeps the last load value.
        if (load_resp) begin
            data_ready_next = 1'b1;
            data_rdata_next = bus.mem_resp_rdata_i;
        end

        if (push && !bus.data_we_i) begin
            ld_cnt_next = ld_cnt_reg + PERF_ONE;
        end
        if (push && bus.data_we_i) begin
            st_cnt_next = st_cnt_reg + PERF_ONE;
        end

        if (orphan_resp) begin
            err_next = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            data_ready_reg <= 1'b0;
            data_rdata_reg <= '0;
            ld_cnt_reg     <= '0;
            st_cnt_reg     <= '0;
            err_reg        <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            data_ready_reg <= data_ready_next;
            data_rdata_reg <= data_rdata_next;
            ld_cnt_reg     <= ld_cnt_next;
            st_cnt_reg     <= st_cnt_next;
            err_reg        <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.data_ready_o = data_ready_reg;
    assign bus.data_rdata_o = data_rdata_reg;
    assign ld_cnt_o         = ld_cnt_reg;
    assign st_cnt_o         = st_cnt_reg;
    assign err_o            = err_reg;

endmodule
